// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : writeback_arbiter_if
// Brief   : Producer-side and regfile-side bundle of the writeback arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface writeback_arbiter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 3
);
    logic                   alu_valid;
    logic [ADDR_WIDTH-1:0]  alu_rd;
    logic [DATA_WIDTH-1:0]  alu_data;
    logic                   alu_ready;
    logic                   mem_valid;
    logic [ADDR_WIDTH-1:0]  mem_rd;
    logic [DATA_WIDTH-1:0]  mem_data;
    logic                   rf_we;
    logic [ADDR_WIDTH-1:0]  rf_waddr;
    logic [DATA_WIDTH-1:0]  rf_wdata;
    logic [COUNT_WIDTH-1:0] fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  alu_ready, rf_we, rf_waddr, rf_wdata, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output alu_ready, rf_we, rf_waddr, rf_wdata, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : writeback_arbiter
// Brief   : Single regfile write port shared by loads (priority) and queued ALU results.
// Revision: 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic           clock,
    input  wire logic           reset_n,
    writeback_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_step = PTR_W'(1);

    logic [ADDR_WIDTH-1:0] r_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_live;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_win;
    logic                  w_win_live;
    logic [ADDR_WIDTH-1:0] w_win_rd;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic [FIFO_DEPTH-1:0] w_squash;

    assign w_full   = (r_count == c_full);
    assign w_empty  = (r_count == '0);
    assign w_accept = bus.alu_valid && !w_full;

    assign bus.alu_ready  = !w_full;
    assign bus.fifo_count = r_count;
    assign bus.rf_we      = r_we;
    assign bus.rf_waddr   = r_waddr;
    assign bus.rf_wdata   = r_wdata;

    // Loads win; otherwise the queue head; an ALU result bypasses only into an empty queue.
    always_comb begin
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_win      = 1'b0;
        w_win_live = 1'b0;
        w_win_rd   = '0;
        w_win_data = '0;
        if (bus.mem_valid) begin
            w_win      = 1'b1;
            w_win_live = 1'b1;
            w_win_rd   = bus.mem_rd;
            w_win_data = bus.mem_data;
            w_push     = w_accept;
        end else if (!w_empty) begin
            w_win      = 1'b1;
            w_win_live = r_live[r_head];
            w_win_rd   = r_rd[r_head];
            w_win_data = r_data[r_head];
            w_pop      = 1'b1;
            w_push     = w_accept;
        end else if (w_accept) begin
            w_win      = 1'b1;
            w_win_live = 1'b1;
            w_win_rd   = bus.alu_rd;
            w_win_data = bus.alu_data;
        end
    end

    // A load makes older queued writes to the same register redundant.
    always_comb begin
        w_squash = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_squash[i] = bus.mem_valid && (bus.mem_rd != '0) && (r_rd[i] == bus.mem_rd);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_rd[r_tail]   <= bus.alu_rd;
            r_data[r_tail] <= bus.alu_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_live  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_live <= r_live & ~w_squash;
            if (w_push) begin
                r_live[r_tail] <= 1'b1;
                r_tail         <= r_tail + c_step;
            end
            if (w_pop) begin
                r_head <= r_head + c_step;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_win) begin
            r_we    <= w_win_live && (w_win_rd != '0);
            r_waddr <= w_win_rd;
            r_wdata <= w_win_data;
        end else begin
            r_we <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_writeback_arbiter
// Brief   : Scoreboard bench for writeback_arbiter; per-cycle expectations queued at drive time.
// Revision: 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;
    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        ew;
        logic        chk;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [2:0]  ecnt;
    } step_t;

    step_t exp_q[$];

    writeback_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .COUNT_WIDTH(3)) bus ();

    writeback_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic step_t mk(logic av, logic [4:0] ard, logic [31:0] adat,
                                 logic mv, logic [4:0] mrd, logic [31:0] mdat,
                                 logic ew, logic chk, logic [4:0] ea, logic [31:0] ed,
                                 logic [2:0] ecnt);
        step_t s;
        s.av = av; s.ard = ard; s.adat = adat;
        s.mv = mv; s.mrd = mrd; s.mdat = mdat;
        s.ew = ew; s.chk = chk; s.ea = ea; s.ed = ed; s.ecnt = ecnt;
        return s;
    endfunction

    task automatic drive(input step_t s);
        bus.alu_valid = s.av;
        bus.alu_rd    = s.ard;
        bus.alu_data  = s.adat;
        bus.mem_valid = s.mv;
        bus.mem_rd    = s.mrd;
        bus.mem_data  = s.mdat;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_rf got we=%0b addr=%0d data=%h required 0/0/0",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        checks++;
        if (bus.fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_count got %0d required 0", bus.fifo_count);
        end
        reset_n = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (bus.alu_ready !== 1'b1 || bus.rf_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got ready=%0b we=%0b required 1/0", bus.alu_ready, bus.rf_we);
        end
    endtask

    task automatic test_bypass();
        step_t st[$];
        step_t e;
        st.push_back(mk(1, 3, 32'h11, 0, 0, 0, 1, 1, 3, 32'h11, 0));
        st.push_back(mk(0, 0, 0,      0, 0, 0, 0, 1, 3, 32'h11, 0));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(st[i]);
            @(posedge clock); #1;
            e = exp_q.pop_front();
            checks++;
            if (bus.rf_we !== e.ew || (e.chk && (bus.rf_waddr !== e.ea || bus.rf_wdata !== e.ed))) begin
                failures++;
                $display("FAIL bypass[%0d] got we=%0b addr=%0d data=%h required %0b/%0d/%h",
                         i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.ew, e.ea, e.ed);
            end
            checks++;
            if (bus.fifo_count !== e.ecnt || bus.alu_ready !== (e.ecnt != 3'd4)) begin
                failures++;
                $display("FAIL bypass_count[%0d] got %0d ready=%0b required %0d",
                         i, bus.fifo_count, bus.alu_ready, e.ecnt);
            end
        end
    endtask

    task automatic test_load_priority();
        step_t st[$];
        step_t e;
        st.push_back(mk(1, 6, 32'hBB, 1, 5, 32'hAA, 1, 1, 5, 32'hAA, 1));
        st.push_back(mk(0, 0, 0,      0, 0, 0,      1, 1, 6, 32'hBB, 0));
        st.push_back(mk(0, 0, 0,      0, 0, 0,      0, 1, 6, 32'hBB, 0));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(st[i]);
            @(posedge clock); #1;
            e = exp_q.pop_front();
            checks++;
            if (bus.rf_we !== e.ew || (e.chk && (bus.rf_waddr !== e.ea || bus.rf_wdata !== e.ed))) begin
                failures++;
                $display("FAIL load_priority[%0d] got we=%0b addr=%0d data=%h required %0b/%0d/%h",
                         i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.ew, e.ea, e.ed);
            end
            checks++;
            if (bus.fifo_count !== e.ecnt || bus.alu_ready !== (e.ecnt != 3'd4)) begin
                failures++;
                $display("FAIL load_priority_count[%0d] got %0d ready=%0b required %0d",
                         i, bus.fifo_count, bus.alu_ready, e.ecnt);
            end
        end
    endtask

    task automatic test_backpressure();
        step_t st[$];
        step_t e;
        st.push_back(mk(1, 1, 32'h01, 1, 10, 32'hA0, 1, 1, 10, 32'hA0, 1));
        st.push_back(mk(1, 2, 32'h02, 1, 11, 32'hA1, 1, 1, 11, 32'hA1, 2));
        st.push_back(mk(1, 3, 32'h03, 1, 12, 32'hA2, 1, 1, 12, 32'hA2, 3));
        st.push_back(mk(1, 4, 32'h04, 1, 13, 32'hA3, 1, 1, 13, 32'hA3, 4));
        st.push_back(mk(1, 5, 32'h05, 1, 14, 32'hA4, 1, 1, 14, 32'hA4, 4));
        st.push_back(mk(1, 5, 32'h05, 1, 15, 32'hA5, 1, 1, 15, 32'hA5, 4));
        st.push_back(mk(1, 5, 32'h05, 0, 0,  0,      1, 1, 1,  32'h01, 3));
        st.push_back(mk(1, 5, 32'h05, 0, 0,  0,      1, 1, 2,  32'h02, 3));
        st.push_back(mk(0, 0, 0,      0, 0,  0,      1, 1, 3,  32'h03, 2));
        st.push_back(mk(0, 0, 0,      0, 0,  0,      1, 1, 4,  32'h04, 1));
        st.push_back(mk(0, 0, 0,      0, 0,  0,      1, 1, 5,  32'h05, 0));
        st.push_back(mk(0, 0, 0,      0, 0,  0,      0, 1, 5,  32'h05, 0));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(st[i]);
            @(posedge clock); #1;
            e = exp_q.pop_front();
            checks++;
            if (bus.rf_we !== e.ew || (e.chk && (bus.rf_waddr !== e.ea || bus.rf_wdata !== e.ed))) begin
                failures++;
                $display("FAIL backpressure[%0d] got we=%0b addr=%0d data=%h required %0b/%0d/%h",
                         i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.ew, e.ea, e.ed);
            end
            checks++;
            if (bus.fifo_count !== e.ecnt || bus.alu_ready !== (e.ecnt != 3'd4)) begin
                failures++;
                $display("FAIL backpressure_count[%0d] got %0d ready=%0b required %0d",
                         i, bus.fifo_count, bus.alu_ready, e.ecnt);
            end
        end
    endtask

    task automatic test_squash();
        step_t st[$];
        step_t e;
        st.push_back(mk(1, 7, 32'h1, 1, 9,  32'h90, 1, 1, 9,  32'h90, 1));
        st.push_back(mk(1, 8, 32'h2, 1, 10, 32'h91, 1, 1, 10, 32'h91, 2));
        st.push_back(mk(0, 0, 0,     1, 7,  32'h3,  1, 1, 7,  32'h3,  2));
        st.push_back(mk(0, 0, 0,     0, 0,  0,      0, 0, 0,  0,      1));
        st.push_back(mk(0, 0, 0,     0, 0,  0,      1, 1, 8,  32'h2,  0));
        st.push_back(mk(0, 0, 0,     0, 0,  0,      0, 1, 8,  32'h2,  0));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(st[i]);
            @(posedge clock); #1;
            e = exp_q.pop_front();
            checks++;
            if (bus.rf_we !== e.ew || (e.chk && (bus.rf_waddr !== e.ea || bus.rf_wdata !== e.ed))) begin
                failures++;
                $display("FAIL squash[%0d] got we=%0b addr=%0d data=%h required %0b/%0d/%h",
                         i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.ew, e.ea, e.ed);
            end
            checks++;
            if (bus.fifo_count !== e.ecnt || bus.alu_ready !== (e.ecnt != 3'd4)) begin
                failures++;
                $display("FAIL squash_count[%0d] got %0d ready=%0b required %0d",
                         i, bus.fifo_count, bus.alu_ready, e.ecnt);
            end
        end
    endtask

    task automatic test_reg_zero();
        step_t st[$];
        step_t e;
        st.push_back(mk(1, 0, 32'h55, 0, 0, 0,      0, 1, 0, 32'h55, 0));
        st.push_back(mk(0, 0, 0,      1, 0, 32'h66, 0, 1, 0, 32'h66, 0));
        st.push_back(mk(1, 0, 32'h77, 1, 4, 32'h44, 1, 1, 4, 32'h44, 1));
        st.push_back(mk(0, 0, 0,      0, 0, 0,      0, 1, 0, 32'h77, 0));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(st[i]);
            @(posedge clock); #1;
            e = exp_q.pop_front();
            checks++;
            if (bus.rf_we !== e.ew || (e.chk && (bus.rf_waddr !== e.ea || bus.rf_wdata !== e.ed))) begin
                failures++;
                $display("FAIL reg_zero[%0d] got we=%0b addr=%0d data=%h required %0b/%0d/%h",
                         i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.ew, e.ea, e.ed);
            end
            checks++;
            if (bus.fifo_count !== e.ecnt || bus.alu_ready !== (e.ecnt != 3'd4)) begin
                failures++;
                $display("FAIL reg_zero_count[%0d] got %0d ready=%0b required %0d",
                         i, bus.fifo_count, bus.alu_ready, e.ecnt);
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'(16 + i); bus.alu_data = 32'(32'hC0 + i);
            bus.mem_valid = 1'b1; bus.mem_rd = 5'(20 + i); bus.mem_data = 32'(32'hD0 + i);
            @(posedge clock); #1;
        end
        checks++;
        if (bus.fifo_count !== 3'd3 || bus.rf_we !== 1'b1) begin
            failures++;
            $display("FAIL midflight_fill got count=%0d we=%0b required 3/1", bus.fifo_count, bus.rf_we);
        end
        idle();
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.fifo_count !== 3'd0 || bus.rf_waddr !== 5'd0) begin
            failures++;
            $display("FAIL midflight_async got we=%0b count=%0d addr=%0d required 0/0/0",
                     bus.rf_we, bus.fifo_count, bus.rf_waddr);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checks++;
            if (bus.rf_we !== 1'b0 || bus.fifo_count !== 3'd0 || bus.alu_ready !== 1'b1) begin
                failures++;
                $display("FAIL midflight_stale[%0d] got we=%0b count=%0d ready=%0b required 0/0/1",
                         i, bus.rf_we, bus.fifo_count, bus.alu_ready);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b1;
        idle();
        #1;
        test_reset();
        test_bypass();
        test_load_priority();
        test_backpressure();
        test_squash();
        test_reg_zero();
        test_reset_midflight();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d leftover required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
